// File: rtl/key_cmd_gen_pkg.sv
// rtl/key_cmd_gen_pkg.sv - key indices and vector width shared with the LED state blocks
package key_cmd_gen_pkg;

  localparam int KEY_W     = 4;
  localparam int KEY_RESET = 0;
  localparam int KEY_IN    = 1;
  localparam int KEY_START = 2;
  localparam int KEY_PAUSE = 3;

  typedef logic [KEY_W-1:0] key_vec_t;

endpackage

// File: rtl/key_cmd_gen_debounce.sv
// rtl/key_cmd_gen_debounce.sv - single-key 2-flop synchronizer, debouncer and press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press
);

  logic             sync1, sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      stable    <= 1'b1;
      cnt       <= '0;
      key_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      key_level <= ~stable;
      // rising edge of the registered level: one pulse per accepted press
      press     <= ~stable & ~key_level;
    end
  end

endmodule

// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - debounced push-buttons turned into pending commands held until a slow tick
module key_cmd_gen
  import key_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_n,
  input  logic             tick,
  output logic             cmd_reset,
  output logic             cmd_in,
  output logic             cmd_start,
  output logic             cmd_pause,
  output logic             run_mode,
  output logic [KEY_W-1:0] key_level,
  output logic [7:0]       drop_cnt
);

  key_vec_t   press;
  logic       p_reset, p_in, p_start, p_pause;
  key_vec_t   drop;
  logic [2:0] n_drop;
  logic [8:0] drop_sum;

  for (genvar g = 0; g < KEY_W; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .key_n    (key_n[g]),
      .key_level(key_level[g]),
      .press    (press[g])
    );
  end

  // reset masks every other press; pause masks a simultaneous start
  always_comb begin
    p_reset = press[KEY_RESET];
    p_in    = press[KEY_IN] & ~p_reset;
    p_pause = press[KEY_PAUSE] & ~p_reset;
    p_start = press[KEY_START] & ~press[KEY_PAUSE] & ~p_reset;

    drop            = '0;
    drop[KEY_RESET] = p_reset & cmd_reset & ~tick;
    drop[KEY_IN]    = p_in & cmd_in & ~tick;
    drop[KEY_START] = p_start & cmd_start & ~tick;
    drop[KEY_PAUSE] = p_pause & cmd_pause & ~tick;

    n_drop = '0;
    for (int i = 0; i < KEY_W; i++) begin
      n_drop = n_drop + {2'b00, drop[i]};
    end
    drop_sum = {1'b0, drop_cnt} + {6'd0, n_drop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_reset <= 1'b0;
      cmd_in    <= 1'b0;
      cmd_start <= 1'b0;
      cmd_pause <= 1'b0;
      run_mode  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      cmd_reset <= p_reset | (cmd_reset & ~tick);
      cmd_in    <= p_in | (~p_reset & cmd_in & ~tick);
      cmd_start <= p_start | (~p_reset & ~p_pause & cmd_start & ~tick);
      cmd_pause <= p_pause | (~p_reset & ~p_start & cmd_pause & ~tick);
      // consumer sees the commands pending before this tick
      if (tick) begin
        if (cmd_reset | cmd_pause) begin
          run_mode <= 1'b0;
        end else if (cmd_start) begin
          run_mode <= 1'b1;
        end
      end
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_key_cmd_gen.sv
// tb/tb_key_cmd_gen.sv - directed self-checking bench for key_cmd_gen
module tb_key_cmd_gen;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       tick;
  logic       cmd_reset, cmd_in, cmd_start, cmd_pause, run_mode;
  logic [3:0] key_level;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  key_cmd_gen #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .tick     (tick),
    .cmd_reset(cmd_reset),
    .cmd_in   (cmd_in),
    .cmd_start(cmd_start),
    .cmd_pause(cmd_pause),
    .run_mode (run_mode),
    .key_level(key_level),
    .drop_cnt (drop_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance n clock edges, leaving time 1 unit past the last edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int idx);
    key_n[idx] = 1'b0;
    cyc(10);
    key_n[idx] = 1'b1;
    cyc(10);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  function automatic logic [3:0] cmds();
    return {cmd_pause, cmd_start, cmd_in, cmd_reset};
  endfunction

  initial begin
    logic seen;
    reset = 1'b1;
    key_n = 4'hF;
    tick  = 1'b0;
    cyc(3);
    reset = 1'b0;
    chk("rst_cmds", cmds(), 4'b0000);
    chk("rst_run", run_mode, 1'b0);
    chk("rst_level", key_level, 4'h0);
    chk("rst_drop", drop_cnt, 8'd0);

    // in key held: level at edge 2+DEB+1, command the edge after
    key_n[1] = 1'b0;
    cyc(2 + DEB);
    chk("in_level_early", key_level, 4'h0);
    cyc(1);
    chk("in_level", key_level, 4'b0010);
    chk("in_cmd_early", cmd_in, 1'b0);
    cyc(1);
    chk("in_cmd", cmd_in, 1'b1);
    cyc(12);
    chk("in_cmd_hold", cmd_in, 1'b1);
    pulse_tick();
    chk("in_cmd_consumed", cmd_in, 1'b0);
    key_n[1] = 1'b1;
    cyc(12);
    chk("in_release", {key_level, cmds()}, 8'h00);

    // 3-cycle glitch on start is rejected
    key_n[2] = 1'b0;
    cyc(3);
    key_n[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      seen = seen | cmd_start | key_level[2];
    end
    chk("glitch_seen", seen, 1'b0);
    chk("glitch_drop", drop_cnt, 8'd0);

    // start then pause, each consumed by a tick
    press_key(2);
    chk("start_pend", cmds(), 4'b0100);
    chk("start_run_before", run_mode, 1'b0);
    pulse_tick();
    chk("start_run", run_mode, 1'b1);
    chk("start_consumed", cmds(), 4'b0000);
    press_key(3);
    chk("pause_pend", cmds(), 4'b1000);
    pulse_tick();
    chk("pause_run", run_mode, 1'b0);
    chk("pause_consumed", cmds(), 4'b0000);

    // in+start pending, reset press wipes them
    press_key(2);
    pulse_tick();
    chk("run_again", run_mode, 1'b1);
    press_key(1);
    press_key(2);
    chk("pend_in_start", cmds(), 4'b0110);
    press_key(0);
    chk("reset_only", cmds(), 4'b0001);
    chk("reset_no_drop", drop_cnt, 8'd0);
    pulse_tick();
    chk("reset_run", run_mode, 1'b0);
    chk("reset_consumed", cmds(), 4'b0000);

    // start and pause in the same cycle: pause wins, no drop
    key_n[3:2] = 2'b00;
    cyc(10);
    key_n[3:2] = 2'b11;
    cyc(10);
    chk("both_pause_wins", cmds(), 4'b1000);
    chk("both_no_drop", drop_cnt, 8'd0);
    pulse_tick();

    // press event coinciding with tick keeps the latch set
    press_key(1);
    key_n[1] = 1'b0;
    cyc(2 + DEB + 1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("tick_and_press", cmd_in, 1'b1);
    chk("tick_and_press_drop", drop_cnt, 8'd0);
    key_n[1] = 1'b1;
    cyc(10);
    pulse_tick();
    chk("tick_and_press_clr", cmd_in, 1'b0);

    // repeated in presses before a tick are dropped, saturating at 255
    press_key(1);
    chk("drop_first", drop_cnt, 8'd0);
    press_key(1);
    chk("drop_one", {cmd_in, drop_cnt}, {1'b1, 8'd1});
    for (int i = 0; i < 300; i++) press_key(1);
    chk("drop_sat", drop_cnt, 8'd255);
    pulse_tick();

    // reset mid-debounce with pause held through it
    press_key(2);
    pulse_tick();
    key_n[3] = 1'b0;
    cyc(4);
    reset = 1'b1;
    cyc(2);
    chk("mid_rst_cmds", cmds(), 4'b0000);
    chk("mid_rst_run", run_mode, 1'b0);
    chk("mid_rst_level", key_level, 4'h0);
    chk("mid_rst_drop", drop_cnt, 8'd0);
    reset = 1'b0;
    cyc(DEB + 2);
    chk("held_level_early", key_level, 4'h0);
    cyc(1);
    chk("held_level", key_level, 4'b1000);
    chk("held_cmd_early", cmd_pause, 1'b0);
    cyc(1);
    chk("held_cmd", cmd_pause, 1'b1);
    cyc(15);
    chk("held_single_event", {cmds(), drop_cnt}, {4'b1000, 8'd0});
    key_n[3] = 1'b1;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
